hex_string_tx: RTL and testbench
================================

HEX_STRING_TX -- requirements
Module: hex_string_tx

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter LOWERCASE, default 0: 1 selects "a".."f" for nibbles A..F; 0 selects "A".."F".
REQ-003 Parameter PREFIX, default 0: 1 emits "0x" before the digits.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_data  in  WIDTH  word to convert; sampled only when a start is accepted.
REQ-007 i_start  in  1  request to convert i_data.
REQ-008 o_busy  out  1  high from the cycle after start acceptance until the final byte transfers.
REQ-009 o_byte  out  8  current ASCII character.
REQ-010 o_valid  out  1  o_byte holds a character to transfer.
REQ-011 i_ready  in  1  downstream (e.g. UART TX) accepts o_byte.
REQ-012 o_done  out  1  one-cycle pulse after the final byte transfers.

Function
REQ-013 A start SHALL be accepted when i_start=1 and o_busy=0; i_data is captured into an internal shift register on that edge.
REQ-014 i_start while o_busy=1 SHALL be ignored; the captured word SHALL NOT change.
REQ-015 A transfer SHALL occur on any edge with o_valid=1 and i_ready=1.
REQ-016 o_valid SHALL rise the cycle after start acceptance (latency 1); i_ready is not required for this.
REQ-017 While o_valid=1 and i_ready=0, o_byte SHALL be held stable.
REQ-018 o_valid SHALL NOT deassert until a transfer occurs.
REQ-019 Character order SHALL be: optional "0x" (PREFIX=1), then WIDTH/4 hex digits MSB nibble first, then optional CR LF (see REQ-029).
REQ-020 Successive characters SHALL present back-to-back: with i_ready held high, one character transfers per cycle with no bubbles.
REQ-021 FSM states SHALL be IDLE, PFX_0, PFX_X, DIGIT, CR, LF.
  - IDLE -> PFX_0 on start (PREFIX=1), else -> DIGIT.
  - PFX_0 -> PFX_X on transfer; PFX_X -> DIGIT on transfer.
  - DIGIT stays in DIGIT until the last nibble transfers; then -> CR if enabled, else -> IDLE.
  - CR -> LF on transfer; LF -> IDLE on transfer.
REQ-022 The digit counter SHALL be $clog2(WIDTH/4) bits wide (minimum 1); it counts transfers in DIGIT, and the last digit is count = WIDTH/4-1.
REQ-023 On each DIGIT transfer the shift register SHALL shift left by 4; o_byte SHALL always encode the top nibble.
REQ-024 When the final character transfers: o_valid=0 and o_busy=0 on the next cycle, and o_done=1 for exactly that cycle.
REQ-025 i_start asserted during the o_done cycle SHALL be accepted (o_busy=0 then).
REQ-026 All digit values 0..F SHALL map to the ASCII codes 0x30..0x39 and 0x41..0x46 (0x61..0x66 when LOWERCASE=1); there is no invalid code.

Reset
REQ-027 Asserting i_rst SHALL immediately force state IDLE, counter 0, shift register 0, and o_valid=0, o_busy=0, o_done=0, o_byte=8'h00, including mid-string; a partial string is abandoned with no o_done.
REQ-028 After i_rst deasserts, the first edge with i_start=1 SHALL be accepted.

Configuration
REQ-029 Macro HEX_STRING_TX_CRLF_EN:
  - Defined: CR (8'h0D) then LF (8'h0A) follow the last digit of every string.
  - Undefined: CR/LF states are not built, and DIGIT -> IDLE after the last digit.

Structure
REQ-030 Package hex_pkg SHALL hold the FSM state encodings and the ASCII constants ("0", "x", CR, LF).
REQ-031 Nibble encoding SHALL be a combinational sub-module hex_nibble_ascii (4-bit in, 8-bit out, LOWERCASE parameter) instantiated once.

Verification
REQ-032 WIDTH=16, defaults, i_data=16'hBEEF, i_ready=1 -> bytes "B","E","E","F" on 4 consecutive cycles starting 1 cycle after start; o_done one cycle after the "F" transfer.
REQ-033 WIDTH=8, PREFIX=1, LOWERCASE=1, i_data=8'h3c -> "0","x","3","c"; with CRLF_EN defined, followed by 0x0D, 0x0A.
REQ-034 i_ready toggled 1010... with i_data=16'h0123 -> o_byte stable while stalled; sequence "0","1","2","3" with no drop or duplicate.
REQ-035 i_start pulsed again during string with i_data=16'hFFFF -> original string unchanged; start in the o_done cycle -> new string begins next cycle.
REQ-036 i_rst asserted after 2 of 4 digits -> all outputs 0 asynchronously, no o_done; next start emits the full new string.
REQ-037 WIDTH=4 (1-bit counter), all 16 nibble values -> correct ASCII mapping for each, in both cases.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared definitions for the hex string transmitter: FSM state encoding,
// ASCII constants and digit-counter sizing.
package hex_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX_0 = 3'd1,
    PFX_X = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } hex_state_e;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  // A single-digit word still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width / 4 > 1) ? $clog2(width / 4) : 1;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble to ASCII hex digit encoder; every 4-bit value has a
// valid character, so there is no error output.
module hex_nibble_ascii
  import hex_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else if (LOWERCASE) begin
      ascii = ASCII_LOWER_A + {4'h0, nibble} - 8'd10;
    end else begin
      ascii = ASCII_UPPER_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_string_tx.sv
// Converts a captured data word into a stream of ASCII hex characters.
// Optional trailing CR LF is built when HEX_STRING_TX_CRLF_EN is defined.
module hex_string_tx
  import hex_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LOWERCASE = 0,
  parameter int PREFIX    = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_start,
  output logic             o_busy,
  output logic [7:0]       o_byte,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done,
  output hex_state_e       o_state
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  hex_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             done_q, done_d;
  logic [7:0]       digit_ascii;
  logic             xfer;

  // Handshake: o_byte moves downstream on every rising edge where
  // o_valid && i_ready; o_valid never drops and o_byte never changes
  // before that edge, and i_ready may depend combinationally on o_valid.
  assign o_valid = (state_q != IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_state = state_q;
  assign xfer    = o_valid && i_ready;

  hex_nibble_ascii #(
    .LOWERCASE(LOWERCASE != 0)
  ) u_nibble (
    .nibble(sh_q[WIDTH-1 -: 4]),
    .ascii (digit_ascii)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          sh_d    = i_data;
          cnt_d   = '0;
          state_d = (PREFIX != 0) ? PFX_0 : DIGIT;
        end
      end
      PFX_0: if (xfer) state_d = PFX_X;
      PFX_X: if (xfer) state_d = DIGIT;
      DIGIT: begin
        if (xfer) begin
          // The top nibble is always the one on o_byte.
          sh_d = sh_q << 4;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef HEX_STRING_TX_CRLF_EN
            state_d = CR;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef HEX_STRING_TX_CRLF_EN
      CR: if (xfer) state_d = LF;
      LF: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_byte = 8'h00;
    case (state_q)
      PFX_0: o_byte = ASCII_ZERO;
      PFX_X: o_byte = ASCII_X;
      DIGIT: o_byte = digit_ascii;
`ifdef HEX_STRING_TX_CRLF_EN
      CR:    o_byte = ASCII_CR;
      LF:    o_byte = ASCII_LF;
`endif
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_hex_string_tx.sv
// Testbench for hex_string_tx: four instances (16-bit default, 8-bit prefixed
// lowercase, 4-bit upper and lower) sharing clock, reset and ready.
module tb_hex_string_tx;
  import hex_pkg::*;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] up;
    logic [7:0] lo;
  } nib_vec_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] data  = '0;
  int          sel   = 0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  logic start_a, start_b, start_c, start_d;
  logic a_busy, a_valid, a_done; logic [7:0] a_byte; hex_state_e a_state;
  logic b_busy, b_valid, b_done; logic [7:0] b_byte; hex_state_e b_state;
  logic c_busy, c_valid, c_done; logic [7:0] c_byte; hex_state_e c_state;
  logic d_busy, d_valid, d_done; logic [7:0] d_byte; hex_state_e d_state;
  logic m_busy, m_valid, m_done; logic [7:0] m_byte; hex_state_e m_state;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign start_d = start && (sel == 3);

  // clock / reset
  always #5 clk = ~clk;

  hex_string_tx #(.WIDTH(16), .LOWERCASE(0), .PREFIX(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_start(start_a),
    .o_busy(a_busy), .o_byte(a_byte), .o_valid(a_valid), .i_ready(ready),
    .o_done(a_done), .o_state(a_state));

  hex_string_tx #(.WIDTH(8), .LOWERCASE(1), .PREFIX(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(data[7:0]), .i_start(start_b),
    .o_busy(b_busy), .o_byte(b_byte), .o_valid(b_valid), .i_ready(ready),
    .o_done(b_done), .o_state(b_state));

  hex_string_tx #(.WIDTH(4), .LOWERCASE(0), .PREFIX(0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_data(data[3:0]), .i_start(start_c),
    .o_busy(c_busy), .o_byte(c_byte), .o_valid(c_valid), .i_ready(ready),
    .o_done(c_done), .o_state(c_state));

  hex_string_tx #(.WIDTH(4), .LOWERCASE(1), .PREFIX(0)) u_d (
    .i_clk(clk), .i_rst(rst), .i_data(data[3:0]), .i_start(start_d),
    .o_busy(d_busy), .o_byte(d_byte), .o_valid(d_valid), .i_ready(ready),
    .o_done(d_done), .o_state(d_state));

  always_comb begin
    m_busy = a_busy; m_valid = a_valid; m_done = a_done; m_byte = a_byte; m_state = a_state;
    case (sel)
      1: begin m_busy = b_busy; m_valid = b_valid; m_done = b_done; m_byte = b_byte; m_state = b_state; end
      2: begin m_busy = c_busy; m_valid = c_valid; m_done = c_done; m_byte = c_byte; m_state = c_state; end
      3: begin m_busy = d_busy; m_valid = d_valid; m_done = d_done; m_byte = d_byte; m_state = d_state; end
      default: ;
    endcase
  end

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_crlf();
`ifdef HEX_STRING_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic push_hex(input logic [15:0] d, input int ndig, input bit lower, input bit pfx);
    exp_q.delete();
    if (pfx) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int i = ndig - 1; i >= 0; i--) exp_q.push_back(hex_char(d[i*4 +: 4], lower));
    push_crlf();
  endtask

  // driver tasks: all driving and sampling happens on the falling edge
  task automatic kick(input logic [15:0] d);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    check("valid_latency", m_valid, 1);
    check("busy_after_start", m_busy, 1);
  endtask

  task automatic collect(input bit toggle, input bit mid);
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] held = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (stalled) check("byte_hold", m_byte, held);
      check("valid_until_xfer", m_valid, 1);
      ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      start = mid && (cyc == 1);
      if (mid && cyc == 1) data = 16'hFFFF;
      if (m_valid && ready) begin
        check("byte", m_byte, exp_q.pop_front());
        stalled = 0;
      end else begin
        stalled = 1;
        held = m_byte;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    check("string_budget", exp_q.size(), 0);
    check("done_pulse", m_done, 1);
    check("valid_after_last", m_valid, 0);
    check("busy_after_last", m_busy, 0);
  endtask

  task automatic send(input logic [15:0] d, input bit toggle, input bit mid);
    @(negedge clk);
    check("done_one_cycle", m_done, 0);
    kick(d);
    collect(toggle, mid);
  endtask

  nib_vec_t vecs[16];
  logic [7:0] up_tab[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic [7:0] lo_tab[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = '{nib: 4'(i), up: up_tab[i], lo: lo_tab[i]};

    // reset state
    #3;
    check("rst_valid", a_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_byte", a_byte, 0);
    check("rst_b_byte", b_byte, 0);
    @(negedge clk);
    rst = 1'b0;

    // 16-bit string, ready held high
    sel = 0;
    push_hex(16'hBEEF, 4, 0, 0);
    send(16'hBEEF, 0, 0);

    // ready toggling 1010...
    push_hex(16'h0123, 4, 0, 0);
    send(16'h0123, 1, 0);

    // start while busy is ignored, then start in the done cycle
    push_hex(16'h5A69, 4, 0, 0);
    send(16'h5A69, 0, 1);
    push_hex(16'hC0DE, 4, 0, 0);
    kick(16'hC0DE);
    collect(0, 0);

    // reset mid-string after two digits
    @(negedge clk);
    kick(16'hA5C3);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_byte", m_byte, 8'h43);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_done", m_done, 0);
    check("mid_rst_byte", m_byte, 0);
    check("mid_rst_state", m_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_rst", m_done, 0);
    end
    push_hex(16'h1234, 4, 0, 0);
    send(16'h1234, 0, 0);

    // 8-bit, prefix, lowercase
    sel = 1;
    push_hex(16'h003C, 2, 1, 1);
    send(16'h003C, 0, 0);
    push_hex(16'h00A7, 2, 1, 1);
    send(16'h00A7, 1, 0);

    // 4-bit instances: full nibble table in both cases
    for (int c = 0; c < 2; c++) begin
      sel = 2 + c;
      for (int i = 0; i < 16; i++) begin
        exp_q.delete();
        exp_q.push_back(c == 1 ? vecs[i].lo : vecs[i].up);
        push_crlf();
        send({12'h000, vecs[i].nib}, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
